// File: rtl/wbus_fabric_pkg.sv
// ---------------------------------------------------------------------------
// wbus_fabric_pkg
// Shared definitions for the W-bus fabric: arbiter FSM state encoding and
// arbitration mode selectors.
// ---------------------------------------------------------------------------
package wbus_fabric_pkg;

  // Arbiter ownership state
  typedef enum logic [1:0] {
    IDLE   = 2'd0,  // no owner
    OWNED  = 2'd1,  // owner granted for one cycle
    LOCKED = 2'd2   // owner retained by lock
  } state_e;

  // Arbitration mode selectors for the MODE parameter
  localparam int MODE_PRIO = 0;  // highest set index wins
  localparam int MODE_RR   = 1;  // round-robin from rr_ptr

endpackage : wbus_fabric_pkg

// File: rtl/wbus_rr_pick.sv
// ---------------------------------------------------------------------------
// wbus_rr_pick
// Combinational winner search over a request vector.
//   req_i   : request vector, one bit per source
//   ptr_i   : start index for the upward (round-robin) search
//   desc_i  : 1 = scan downward from N_SRC-1 (fixed priority, ptr_i ignored)
//   win_o   : index of the first set request found
//   found_o : 1 when at least one request is set
// The upward search walks a doubled copy of req_i starting at ptr_i, so the
// wrap from N_SRC-1 back to 0 needs no special case.
// ---------------------------------------------------------------------------
module wbus_rr_pick #(
  parameter int N_SRC = 9,
  parameter int IDXW  = 4
) (
  input  logic [N_SRC-1:0] req_i,
  input  logic [IDXW-1:0]  ptr_i,
  input  logic             desc_i,
  output logic [IDXW-1:0]  win_o,
  output logic             found_o
);

  logic [2*N_SRC-1:0] dbl_s;
  logic               hit_s;
  logic [IDXW-1:0]    cand_s;
  int                 pos_s;

  assign dbl_s = {req_i, req_i};

  // First-hit search; later candidates cannot override an earlier hit
  always_comb begin
    win_o   = '0;
    found_o = 1'b0;
    hit_s   = 1'b0;
    cand_s  = '0;
    pos_s   = 0;
    for (int k = 0; k < N_SRC; k++) begin
      if (desc_i) begin
        hit_s  = req_i[N_SRC-1-k];
        cand_s = IDXW'(N_SRC-1-k);
      end else begin
        pos_s  = int'(ptr_i) + k;
        hit_s  = dbl_s[pos_s];
        cand_s = (pos_s >= N_SRC) ? IDXW'(pos_s - N_SRC) : IDXW'(pos_s);
      end
      win_o   = (hit_s && !found_o) ? cand_s : win_o;
      found_o = found_o | hit_s;
    end
  end

endmodule : wbus_rr_pick

// File: rtl/wbus_fabric.sv
// ---------------------------------------------------------------------------
// wbus_fabric
// Registered shared W-bus: gathers N_SRC sources onto one bus with
// fixed-priority or round-robin arbitration, optional multi-cycle lock,
// and contention flagging. All outputs are registered (1-cycle latency).
//   CLK               : clock, rising edge
//   CLR               : asynchronous active-high reset
//   req               : per-source bus enable
//   src_data          : source i at [i*WIDTH +: WIDTH]
//   lock              : owner keeps the bus while it still requests
//   clr_sticky        : clears contention_sticky
//   bus / bus_valid   : registered bus value / data granted last cycle
//   grant / grant_idx : one-hot owner (0 when idle) / owner index (held)
//   contention        : more than one request in the previous cycle
//   contention_sticky : latched contention indicator
// ---------------------------------------------------------------------------
module wbus_fabric
  import wbus_fabric_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N_SRC = 9,
  parameter int MODE  = 0,
  parameter int HOLD  = 1,
  parameter int IDXW  = (N_SRC > 2) ? $clog2(N_SRC) : 1
) (
  input  logic                   CLK,
  input  logic                   CLR,
  input  logic [N_SRC-1:0]       req,
  input  logic [N_SRC*WIDTH-1:0] src_data,
  input  logic                   lock,
  input  logic                   clr_sticky,
  output logic [WIDTH-1:0]       bus,
  output logic                   bus_valid,
  output logic [N_SRC-1:0]       grant,
  output logic [IDXW-1:0]        grant_idx,
  output logic                   contention,
  output logic                   contention_sticky
);

  state_e           state_q, state_d;
  logic [IDXW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] bus_q, bus_d;
  logic             bus_valid_q, bus_valid_d;
  logic [N_SRC-1:0] grant_q, grant_d;
  logic [IDXW-1:0]  grant_idx_q, grant_idx_d;
  logic             cont_q, cont_d;
  logic             sticky_q, sticky_d;

  logic [WIDTH-1:0] src_arr_s [N_SRC];
  logic [IDXW-1:0]  win_s;
  logic             found_s;
  logic             multi_s;
  logic             keep_s;
  logic [IDXW-1:0]  ptr_next_s;

  for (genvar g = 0; g < N_SRC; g++) begin : g_unpack
    assign src_arr_s[g] = src_data[g*WIDTH +: WIDTH];
  end

  // Clearing the lowest set bit leaves something only if two or more were set
  assign multi_s = |(req & (req - N_SRC'(1)));

  assign ptr_next_s = (win_s == IDXW'(N_SRC-1)) ? '0 : (win_s + IDXW'(1));

  wbus_rr_pick #(
    .N_SRC (N_SRC),
    .IDXW  (IDXW)
  ) u_pick (
    .req_i   (req),
    .ptr_i   ((MODE == MODE_RR) ? rr_ptr_q : '0),
    .desc_i  ((MODE == MODE_RR) ? 1'b0 : 1'b1),
    .win_o   (win_s),
    .found_o (found_s)
  );

  // State and output registers
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      bus_q       <= '0;
      bus_valid_q <= 1'b0;
      grant_q     <= '0;
      grant_idx_q <= '0;
      cont_q      <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      bus_q       <= bus_d;
      bus_valid_q <= bus_valid_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      cont_q      <= cont_d;
      sticky_q    <= sticky_d;
    end
  end

  // Next-state: idle, keep locked owner, or arbitrate a new winner
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    bus_d       = bus_q;
    bus_valid_d = bus_valid_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    keep_s      = 1'b0;
    // Contention is judged on raw requests, independent of lock
    cont_d      = multi_s;
    sticky_d    = multi_s | (sticky_q & ~clr_sticky);

    case (state_q)
      LOCKED:      keep_s = lock & req[grant_idx_q];
      IDLE, OWNED: keep_s = 1'b0;
      default:     keep_s = 1'b0;
    endcase

    if (!found_s) begin
      state_d     = IDLE;
      bus_valid_d = 1'b0;
      grant_d     = '0;
      bus_d       = (HOLD != 0) ? bus_q : '0;
    end else if (keep_s) begin
      // Locked owner: bus follows its data, round-robin pointer frozen
      state_d     = LOCKED;
      bus_d       = src_arr_s[grant_idx_q];
      bus_valid_d = 1'b1;
    end else begin
      state_d     = lock ? LOCKED : OWNED;
      bus_d       = src_arr_s[win_s];
      bus_valid_d = 1'b1;
      grant_d     = N_SRC'(1) << win_s;
      grant_idx_d = win_s;
      rr_ptr_d    = (MODE == MODE_RR) ? ptr_next_s : rr_ptr_q;
    end
  end

  assign bus               = bus_q;
  assign bus_valid         = bus_valid_q;
  assign grant             = grant_q;
  assign grant_idx         = grant_idx_q;
  assign contention        = cont_q;
  assign contention_sticky = sticky_q;

endmodule : wbus_fabric

// File: tb/tb_wbus_fabric.sv
// ---------------------------------------------------------------------------
// tb_wbus_fabric
// Two fabric instances share one stimulus: a fixed-priority bus that zeroes
// when idle, and a round-robin bus that holds when idle. A behavioural model
// built from the arbitration rules predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_wbus_fabric;

  localparam int W = 16;
  localparam int N = 9;
  localparam int IW = 4;

  logic           CLK = 1'b0;
  logic           CLR = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] src_data = '0;
  logic           lock = 1'b0;
  logic           clr_sticky = 1'b0;

  logic [W-1:0]  bus_p, bus_r;
  logic          valid_p, valid_r;
  logic [N-1:0]  grant_p, grant_r;
  logic [IW-1:0] idx_p, idx_r;
  logic          cont_p, cont_r;
  logic          stk_p, stk_r;

  int n_checks = 0;
  int n_errors = 0;

  // Model state, index 0 = priority/zero-idle, 1 = round-robin/hold-idle
  logic [W-1:0] m_bus   [2];
  logic         m_valid [2];
  int           m_idx   [2];
  logic         m_lock  [2];
  int           m_ptr   [2];
  logic         m_cont;
  logic         m_stk;

  wbus_fabric #(.WIDTH(W), .N_SRC(N), .MODE(0), .HOLD(0)) dut_p (
    .CLK(CLK), .CLR(CLR), .req(req), .src_data(src_data), .lock(lock),
    .clr_sticky(clr_sticky), .bus(bus_p), .bus_valid(valid_p), .grant(grant_p),
    .grant_idx(idx_p), .contention(cont_p), .contention_sticky(stk_p)
  );

  wbus_fabric #(.WIDTH(W), .N_SRC(N), .MODE(1), .HOLD(1)) dut_r (
    .CLK(CLK), .CLR(CLR), .req(req), .src_data(src_data), .lock(lock),
    .clr_sticky(clr_sticky), .bus(bus_r), .bus_valid(valid_r), .grant(grant_r),
    .grant_idx(idx_r), .contention(cont_r), .contention_sticky(stk_r)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input int mode, input logic [N-1:0] r, input int ptr);
    if (mode == 0) begin
      for (int i = N - 1; i >= 0; i--) if (r[i]) return i;
    end else begin
      for (int k = 0; k < N; k++) if (r[(ptr + k) % N]) return (ptr + k) % N;
    end
    return 0;
  endfunction

  function automatic logic [W-1:0] src_of(input int i);
    return src_data[i*W +: W];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_bus[d] = '0; m_valid[d] = 1'b0; m_idx[d] = 0; m_lock[d] = 1'b0; m_ptr[d] = 0;
    end
    m_cont = 1'b0;
    m_stk  = 1'b0;
  endtask

  // Apply one clock of the arbitration rules to the model
  task automatic model_step();
    int w;
    for (int d = 0; d < 2; d++) begin
      if (req == '0) begin
        m_valid[d] = 1'b0;
        m_lock[d]  = 1'b0;
        if (d == 0) m_bus[d] = '0;
      end else if (m_lock[d] && lock && req[m_idx[d]]) begin
        m_bus[d]   = src_of(m_idx[d]);
        m_valid[d] = 1'b1;
      end else begin
        w          = pick(d, req, m_ptr[d]);
        m_bus[d]   = src_of(w);
        m_valid[d] = 1'b1;
        m_idx[d]   = w;
        m_lock[d]  = lock;
        if (d == 1) m_ptr[d] = (w + 1) % N;
      end
    end
    m_cont = ($countones(req) > 1);
    m_stk  = m_cont | (m_stk & ~clr_sticky);
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0] g0, g1;
    g0 = m_valid[0] ? (N'(1) << m_idx[0]) : '0;
    g1 = m_valid[1] ? (N'(1) << m_idx[1]) : '0;
    check({tag, ".p.bus"},   32'(bus_p),   32'(m_bus[0]));
    check({tag, ".p.valid"}, 32'(valid_p), 32'(m_valid[0]));
    check({tag, ".p.grant"}, 32'(grant_p), 32'(g0));
    check({tag, ".p.idx"},   32'(idx_p),   32'(m_idx[0]));
    check({tag, ".p.cont"},  32'(cont_p),  32'(m_cont));
    check({tag, ".p.stk"},   32'(stk_p),   32'(m_stk));
    check({tag, ".r.bus"},   32'(bus_r),   32'(m_bus[1]));
    check({tag, ".r.valid"}, 32'(valid_r), 32'(m_valid[1]));
    check({tag, ".r.grant"}, 32'(grant_r), 32'(g1));
    check({tag, ".r.idx"},   32'(idx_r),   32'(m_idx[1]));
    check({tag, ".r.cont"},  32'(cont_r),  32'(m_cont));
    check({tag, ".r.stk"},   32'(stk_r),   32'(m_stk));
  endtask

  // One clock: model follows the edge, outputs sampled 1 time unit later
  task automatic cycle(input string tag);
    @(posedge CLK);
    model_step();
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic do_reset();
    @(posedge CLK);
    #2;
    CLR = 1'b1;
    #1;
    model_reset();
    check_all("rst_async");
    #2;
    req = '0; lock = 1'b0; clr_sticky = 1'b0;
    CLR = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    CLR = 1'b0;
    @(negedge CLK);

    // Reset mid-run with all sources requesting
    req = 9'h1FF;
    for (int i = 0; i < N; i++) src_data[i*W +: W] = 16'(16'h1000 + i);
    cycle("pre_rst");
    cycle("pre_rst");
    do_reset();
    check("rst.bus_p", 32'(bus_p), 32'h0);
    check("rst.grant_r", 32'(grant_r), 32'h0);
    cycle("post_rst");
    check("post_rst.valid_r", 32'(valid_r), 32'h0);
    check("post_rst.bus_r", 32'(bus_r), 32'h0);

    // Fixed priority: highest index wins, two requesters contend
    req = 9'b000000101;
    src_data[0*W +: W] = 16'h1111;
    src_data[2*W +: W] = 16'h2222;
    cycle("prio");
    check("prio.bus", 32'(bus_p), 32'h2222);
    check("prio.grant", 32'(grant_p), 32'h004);
    check("prio.idx", 32'(idx_p), 32'd2);
    check("prio.cont", 32'(cont_p), 32'd1);
    check("prio.stk", 32'(stk_p), 32'd1);

    // Round-robin rotation with wrap
    do_reset();
    req = 9'h1FF;
    for (int k = 0; k < 10; k++) begin
      cycle("rr_seq");
      check("rr_seq.idx", 32'(idx_r), 32'(k % N));
    end

    // Lock: owner 3 held while src3 changes, then released to 4
    do_reset();
    req = 9'h1FF;
    for (int k = 0; k < 3; k++) cycle("lk_pre");
    lock = 1'b1;
    cycle("lk_take");
    check("lk_take.idx", 32'(idx_r), 32'd3);
    for (int k = 0; k < 4; k++) begin
      src_data[3*W +: W] = 16'(16'hA000 + k);
      cycle("lk_hold");
      check("lk_hold.idx", 32'(idx_r), 32'd3);
      check("lk_hold.bus", 32'(bus_r), 32'(16'hA000 + k));
    end
    lock = 1'b0;
    cycle("lk_rel");
    check("lk_rel.idx", 32'(idx_r), 32'd4);

    // Idle behaviour after a single grant of source 5
    req = 9'b000100000;
    src_data[5*W +: W] = 16'hBEEF;
    cycle("idle_grant");
    req = '0;
    cycle("idle");
    check("idle.bus_r", 32'(bus_r), 32'hBEEF);
    check("idle.valid_r", 32'(valid_r), 32'd0);
    check("idle.grant_r", 32'(grant_r), 32'd0);
    check("idle.idx_r", 32'(idx_r), 32'd5);
    check("idle.bus_p", 32'(bus_p), 32'd0);
    check("idle.idx_p", 32'(idx_p), 32'd5);

    // Sticky: new contention beats clear, then clear with single request
    do_reset();
    req = 9'b000000011;
    clr_sticky = 1'b1;
    cycle("stk_set");
    check("stk_set.stk", 32'(stk_r), 32'd1);
    req = 9'b000000001;
    cycle("stk_clr");
    check("stk_clr.stk", 32'(stk_r), 32'd0);
    clr_sticky = 1'b0;

    // Randomised traffic against the model
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 3))
        0:       req = '0;
        1:       req = N'(1) << $urandom_range(0, N - 1);
        2:       req = req;
        default: req = N'($urandom);
      endcase
      for (int i = 0; i < N; i++) src_data[i*W +: W] = 16'($urandom);
      lock       = ($urandom_range(0, 2) != 0);
      clr_sticky = ($urandom_range(0, 7) == 0);
      cycle("rand");
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_wbus_fabric

// File: doc/wbus_fabric.md
Name: wbus_fabric

Overview:
- Parametrised successor to the CPU's shared W-bus driver.
- Gathers N_SRC source registers onto one registered bus.
- Arbitrates between them in fixed-priority or round-robin mode, with optional multi-cycle lock.
- Flags contention (more than one source enabled) and drives one-hot grant back to the sources; sits between the register/port outputs and all bus loads (IR, MAR, output ports).

Parameters:
- WIDTH, 16, bus data width in bits (≥1).
- N_SRC, 9, number of bus sources (≥2).
- MODE, 0, 0 = fixed priority (highest index wins), 1 = round-robin.
- HOLD, 1, 1 = bus keeps last value when idle; 0 = bus returns to zero when idle.
- IDXW, $clog2(N_SRC), width of grant_idx (derived, minimum 1).

Ports:
- CLK  in  1  system clock, rising edge.
- CLR  in  1  asynchronous, active-high reset.
- req  in  N_SRC  per-source bus enable (Ep, Ea, Em, … equivalent).
- src_data  in  N_SRC*WIDTH  source data, source i at bits [i*WIDTH +: WIDTH].
- lock  in  1  current owner keeps the bus while it still requests.
- clr_sticky  in  1  clears contention_sticky.
- bus  out  WIDTH  registered bus value.
- bus_valid  out  1  bus carries data granted in the previous cycle.
- grant  out  N_SRC  registered one-hot owner, zero when idle.
- grant_idx  out  IDXW  index of current owner, holds last owner when idle.
- contention  out  1  one-cycle pulse: popcount(req) > 1 in the previous cycle.
- contention_sticky  out  1  latched contention indicator.

Behaviour:
- One clock domain; all outputs registered. Latency is 1 cycle from req/src_data sample to bus/grant.
- Reset (async, CLR=1) sets:
  - bus = 0, bus_valid = 0, grant = 0, grant_idx = 0
  - contention = 0, contention_sticky = 0
  - rr_ptr = 0, state = IDLE
- Reset mid-transfer aborts immediately; the first post-reset edge arbitrates fresh.
- FSM states:
  - IDLE: no owner.
  - OWNED: owner granted for one cycle.
  - LOCKED: owner retained by lock.
- Transitions:
  - Any state with req == 0: go to IDLE.
  - IDLE or OWNED with req != 0: arbitrate and go to OWNED, or to LOCKED if lock = 1.
  - LOCKED with lock = 1 and req[owner] = 1: stay LOCKED, same owner, other requests ignored for the grant but still counted for contention.
  - LOCKED with lock = 0 or req[owner] = 0: re-arbitrate as from OWNED.
- MODE 0 winner: highest set index of req. This preserves the legacy "last enable wins" ordering.
- MODE 1 winner: first set req searching upward from rr_ptr, wrapping N_SRC-1 to 0.
  - On each new grant, rr_ptr ← (winner+1) mod N_SRC; wrap at N_SRC-1 goes to 0.
  - rr_ptr is unchanged while LOCKED or IDLE.
- On grant:
  - bus ← src_data[winner]
  - bus_valid ← 1
  - grant ← onehot(winner)
  - grant_idx ← winner
- While LOCKED, bus tracks the owner's src_data every cycle.
- Idle (req == 0):
  - bus_valid ← 0, grant ← 0.
  - bus ← bus if HOLD=1, else 0.
  - grant_idx holds its last value.
- Contention:
  - contention ← (popcount(req) > 1), evaluated every cycle regardless of lock.
  - contention_sticky ← 1 when contention is detected.
  - clr_sticky clears it; a simultaneous new contention wins (sticky stays 1).
- No combinational path from req to any output.

Decomposition:
- Shared package holds:
  - state encoding localparams IDLE=2'd0, OWNED=2'd1, LOCKED=2'd2
  - MODE constants MODE_PRIO=0, MODE_RR=1
- One natural sub-module, wbus_rr_pick: combinational, given req and rr_ptr returns winner index and a found bit.
  - Implemented via doubled-vector rotate search.
  - Reused for MODE 0 by forcing a descending scan.

Test Plan:
- Reset: assert CLR mid-run with req=9'h1FF → all outputs 0 asynchronously; after release with req=0, bus stays 0 and bus_valid=0.
- MODE 0, req=9'b000000101, src0=16'h1111, src2=16'h2222 → next cycle bus=16'h2222, grant=9'b000000100, grant_idx=2, contention=1, contention_sticky=1.
- MODE 1, req=9'h1FF held for 10 cycles → grant_idx sequence 0,1,…,8,0 (wrap); rr_ptr=1 after the final grant.
- Lock: MODE 1, owner 3 granted with lock=1, req=9'h1FF for 4 cycles → grant_idx stays 3 and bus follows src3 changes. Then lock=0 → next grant_idx=4.
- Idle hold: HOLD=1, grant src5=16'hBEEF then req=0 → bus stays 16'hBEEF, bus_valid=0, grant=0, grant_idx=5. With HOLD=0 → bus=0.
- Sticky clear: contention in cycle n with clr_sticky=1 in cycle n → sticky stays 1. Then clr_sticky=1 with single req → sticky=0.
